div_issue_ctrl: RTL and testbench

Pipeline-side initiator for the 34-cycle iterative divider (div_start/div_end, div_op, dividend/divisor in, 64-bit {rem,quo} out). It accepts a DIV/DIVU from the EX stage, stalls the pipeline, and drives div_start as a single-cycle pulse. It holds operands stable for the full operation, captures the result, and writes HI/LO. It also handles pipeline flush (drain without writeback), divide-by-zero bypass and a watchdog timeout.

---
 rtl/div_issue_ctrl_if.sv | 39 +++
 rtl/div_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl_if
// Brief    : Pipeline request and iterative-divider handshake bundle for
//            div_issue_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface div_issue_ctrl_if;
    logic        req_valid;
    logic        req_signed;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic        flush;
    logic        stall;
    logic        div_start;
    logic        div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [63:0] div_result;
    logic        div_end;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        busy;
    logic        err_timeout;

    modport slave (
        input  req_valid, req_signed, req_rs, req_rt, flush, div_result, div_end,
        output stall, div_start, div_op, dividend, divisor, hilo_we,
               hi_wdata, lo_wdata, busy, err_timeout
    );

    modport master (
        output req_valid, req_signed, req_rs, req_rt, flush, div_result, div_end,
        input  stall, div_start, div_op, dividend, divisor, hilo_we,
               hi_wdata, lo_wdata, busy, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Brief    : Issues DIV/DIVU to a 34-cycle iterative divider, stalls the
//            pipeline and writes HI/LO; handles flush, divide-by-zero, timeout.
// Revision : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
    parameter int unsigned TIMEOUT     = 64,
    parameter bit          DIV0_BYPASS = 1'b1
) (
    input wire              clk,
    input wire              reset,
    div_issue_ctrl_if.slave bus
);

    localparam int unsigned           c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0]    c_CNT_MAX = c_CNT_W'(TIMEOUT);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ISSUE = 3'd1;
    localparam logic [2:0] c_ARM   = 3'd2;
    localparam logic [2:0] c_WAIT  = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;
    localparam logic [2:0] c_RESP  = 3'd5;

    logic [2:0]         r_state;
    logic               r_op_signed;
    logic [31:0]        r_op_rs;
    logic [31:0]        r_op_rt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy_seen;

    logic w_in_flight;
    logic w_drive;
    logic w_timeout;

    assign w_in_flight = (r_state == c_ARM) || (r_state == c_WAIT) || (r_state == c_DRAIN);
    assign w_drive     = w_in_flight || (r_state == c_ISSUE);
    assign w_timeout   = w_in_flight && (r_cnt == c_CNT_MAX);

    assign bus.stall       = bus.req_valid & ~bus.flush & (r_state != c_RESP);
    // A flush in ISSUE must keep the start pulse from ever reaching the divider
    assign bus.div_start   = (r_state == c_ISSUE) & ~bus.flush;
    assign bus.div_op      = w_drive & r_op_signed;
    assign bus.dividend    = w_drive ? r_op_rs : 32'd0;
    assign bus.divisor     = w_drive ? r_op_rt : 32'd0;
    assign bus.hilo_we     = (r_state == c_RESP) & ~bus.flush;
    assign bus.hi_wdata    = r_hi;
    assign bus.lo_wdata    = r_lo;
    assign bus.busy        = (r_state != c_IDLE);
    assign bus.err_timeout = w_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_op_signed <= 1'b0;
            r_op_rs     <= 32'd0;
            r_op_rt     <= 32'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_cnt       <= '0;
            r_busy_seen <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.req_valid && !bus.flush) begin
                        r_op_signed <= bus.req_signed;
                        r_op_rs     <= bus.req_rs;
                        r_op_rt     <= bus.req_rt;
                        if (DIV0_BYPASS && (bus.req_rt == 32'd0)) begin
                            r_hi    <= bus.req_rs;
                            r_lo    <= 32'hFFFF_FFFF;
                            r_state <= c_RESP;
                        end else begin
                            r_state <= c_ISSUE;
                        end
                    end
                end
                c_ISSUE: begin
                    if (bus.flush) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt       <= '0;
                        r_busy_seen <= 1'b0;
                        r_state     <= c_ARM;
                    end
                end
                c_ARM: begin
                    if (w_timeout) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (!bus.div_end) r_busy_seen <= 1'b1;
                        if (bus.flush)          r_state <= c_DRAIN;
                        else if (!bus.div_end)  r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (w_timeout) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (bus.flush) begin
                            r_state <= c_DRAIN;
                        end else if (bus.div_end) begin
                            r_hi    <= bus.div_result[63:32];
                            r_lo    <= bus.div_result[31:0];
                            r_state <= c_RESP;
                        end
                    end
                end
                c_DRAIN: begin
                    // Divider must be seen busy then idle again before a new start is safe
                    if (w_timeout) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (!bus.div_end) r_busy_seen <= 1'b1;
                        if (r_busy_seen && bus.div_end) r_state <= c_IDLE;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_issue_ctrl
// Brief    : Directed bench for div_issue_ctrl with a 34-cycle divider model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;

    localparam int unsigned c_TIMEOUT = 64;

    logic clk;
    logic reset;
    int   n_compared;
    int   n_mismatched;

    div_issue_ctrl_if bus ();

    div_issue_ctrl #(
        .TIMEOUT     (c_TIMEOUT),
        .DIV0_BYPASS (1'b1)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider: accepts start when idle, busy for 34 cycles
    int unsigned div_cnt;
    logic [63:0] div_res;
    logic        hold_idle;

    function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            div_cnt <= 0;
            div_res <= '0;
        end else if (div_cnt != 0) begin
            div_cnt <= div_cnt - 1;
        end else if (bus.div_start && !hold_idle) begin
            div_cnt <= 34;
            div_res <= model_div(bus.div_op, bus.dividend, bus.divisor);
        end
    end

    assign bus.div_end    = (div_cnt == 0);
    assign bus.div_result = div_res;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctrl_bits();
        return {bus.stall, bus.div_start, bus.div_op, bus.hilo_we, bus.busy, bus.err_timeout};
    endfunction

    // Issue one request, hold it until stall drops, record events relative to cycle 0
    task automatic run_op(input logic sgn, input logic [31:0] rs, input logic [31:0] rt,
                          input int max_cyc, output int n_start, output int start_cyc,
                          output int we_cyc, output int stall_low_cyc,
                          output logic [31:0] hi, output logic [31:0] lo, output logic op_ok);
        n_start = 0; start_cyc = -1; we_cyc = -1; stall_low_cyc = -1;
        hi = '0; lo = '0; op_ok = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_signed = sgn;
        bus.req_rs     = rs;
        bus.req_rt     = rt;
        for (int c = 0; c <= max_cyc; c++) begin
            @(negedge clk);
            if (bus.div_start) begin
                n_start++;
                if (start_cyc < 0) start_cyc = c;
            end
            if (bus.busy && !bus.hilo_we &&
                (bus.div_op !== sgn || bus.dividend !== rs || bus.divisor !== rt)) op_ok = 1'b0;
            if (bus.hilo_we && we_cyc < 0) begin
                we_cyc = c;
                hi     = bus.hi_wdata;
                lo     = bus.lo_wdata;
            end
            if (!bus.stall && stall_low_cyc < 0) stall_low_cyc = c;
            @(posedge clk); #1;
            if (stall_low_cyc >= 0) bus.req_valid = 1'b0;
            if (we_cyc >= 0) break;
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int          n_start, s1, s2, we_cyc, stall_low, n_we, n_err, err_cyc;
        logic [31:0] hi, lo;
        logic        op_ok, stall36, busy67;

        n_compared = 0; n_mismatched = 0; hold_idle = 1'b0;
        bus.req_valid = 1'b0; bus.req_signed = 1'b0;
        bus.req_rs = '0; bus.req_rt = '0; bus.flush = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ctrl", ctrl_bits(), 6'b0);
        check("reset_operands", {bus.dividend, bus.divisor}, 64'd0);
        check("reset_hilo", {bus.hi_wdata, bus.lo_wdata}, 64'd0);
        @(posedge clk); #1;

        // DIVU 100/7, then DIV -7/2 and DIVU 5/0 back to back
        run_op(1'b0, 32'd100, 32'd7, 60, n_start, s1, we_cyc, stall_low, hi, lo, op_ok);
        check("divu_start_cnt", n_start, 1);
        check("divu_start_cyc", s1, 1);
        check("divu_we_cyc", we_cyc, 37);
        check("divu_stall_low", stall_low, 37);
        check("divu_hi", hi, 32'd2);
        check("divu_lo", lo, 32'd14);
        check("divu_ops_held", op_ok, 1'b1);

        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 60, n_start, s1, we_cyc, stall_low, hi, lo, op_ok);
        check("div_we_cyc", we_cyc, 37);
        check("div_op_held", op_ok, 1'b1);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);

        run_op(1'b0, 32'd5, 32'd0, 10, n_start, s1, we_cyc, stall_low, hi, lo, op_ok);
        check("div0_start_cnt", n_start, 0);
        check("div0_we_cyc", we_cyc, 1);
        check("div0_hi", hi, 32'd5);
        check("div0_lo", lo, 32'hFFFF_FFFF);

        // Flush in WAIT at cycle 10, new DIVU 9/3 from cycle 12
        n_start = 0; s1 = -1; s2 = -1; n_we = 0; we_cyc = -1; stall36 = 1'b0;
        bus.req_valid = 1'b1; bus.req_signed = 1'b0; bus.req_rs = 32'd100; bus.req_rt = 32'd7;
        for (int c = 0; c <= 90; c++) begin
            @(negedge clk);
            if (bus.div_start) begin
                n_start++;
                if (s1 < 0) s1 = c;
                else if (s2 < 0) s2 = c;
            end
            if (bus.hilo_we) begin
                n_we++; we_cyc = c; hi = bus.hi_wdata; lo = bus.lo_wdata;
            end
            if (c == 36) stall36 = bus.stall;
            @(posedge clk); #1;
            if (c + 1 == 10) begin bus.flush = 1'b1; bus.req_valid = 1'b0; end
            if (c + 1 == 11) bus.flush = 1'b0;
            if (c + 1 == 12) begin bus.req_valid = 1'b1; bus.req_rs = 32'd9; bus.req_rt = 32'd3; end
            if (we_cyc >= 0) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        check("flush_start_cnt", n_start, 2);
        check("flush_start1_cyc", s1, 1);
        check("flush_start2_cyc", s2, 38);
        check("flush_stall_drain", stall36, 1'b1);
        check("flush_we_cnt", n_we, 1);
        check("flush_we_cyc", we_cyc, 74);
        check("flush_hi", hi, 32'd0);
        check("flush_lo", lo, 32'd3);

        // Divider never leaves idle: watchdog abort
        hold_idle = 1'b1;
        n_start = 0; n_we = 0; n_err = 0; err_cyc = -1; busy67 = 1'b1;
        bus.req_valid = 1'b1; bus.req_signed = 1'b0; bus.req_rs = 32'd1; bus.req_rt = 32'd1;
        for (int c = 0; c <= 80; c++) begin
            @(negedge clk);
            if (bus.div_start) n_start++;
            if (bus.hilo_we) n_we++;
            if (bus.err_timeout) begin
                n_err++;
                if (err_cyc < 0) err_cyc = c;
            end
            if (c == 67) busy67 = bus.busy;
            @(posedge clk); #1;
            if (err_cyc >= 0) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        hold_idle = 1'b0;
        check("tmo_start_cnt", n_start, 1);
        check("tmo_err_cyc", err_cyc, 66);
        check("tmo_err_cnt", n_err, 1);
        check("tmo_we_cnt", n_we, 0);
        check("tmo_busy_after", busy67, 1'b0);

        // Reset in WAIT at cycle 20, then a normal request
        bus.req_valid = 1'b1; bus.req_signed = 1'b0; bus.req_rs = 32'd100; bus.req_rt = 32'd7;
        for (int c = 0; c <= 21; c++) begin
            @(negedge clk);
            if (c == 19) check("rst_busy_before", bus.busy, 1'b1);
            if (c == 21) begin
                check("rst_ctrl", ctrl_bits(), 6'b0);
                check("rst_operands", {bus.dividend, bus.divisor}, 64'd0);
                check("rst_hilo", {bus.hi_wdata, bus.lo_wdata}, 64'd0);
            end
            @(posedge clk); #1;
            if (c + 1 == 20) begin reset = 1'b1; bus.req_valid = 1'b0; end
            if (c + 1 == 21) reset = 1'b0;
        end
        run_op(1'b0, 32'd50, 32'd6, 60, n_start, s1, we_cyc, stall_low, hi, lo, op_ok);
        check("post_rst_start_cyc", s1, 1);
        check("post_rst_we_cyc", we_cyc, 37);
        check("post_rst_hi", hi, 32'd2);
        check("post_rst_lo", lo, 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
